// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the two-core L2 port arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef logic core_id_t;

    localparam int unsigned GAP_CYCLES_DEFAULT = 2;

    // Field layout of the packed statistics word.
    localparam int unsigned STAT_W         = 8;
    localparam int unsigned STAT_C0_LSB    = 24;
    localparam int unsigned STAT_C1_LSB    = 16;
    localparam int unsigned STAT_CONT_LSB  = 8;
    localparam int unsigned STAT_STALL_LSB = 0;

endpackage

// File: rtl/l2_arb_stats.sv
// Four 8-bit wrapping event counters packed into one statistics word.
module l2_arb_stats
    import l2_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        c0_grant,
    input  logic        c1_grant,
    input  logic        contention,
    input  logic        stall,
    output logic [31:0] arb_statistics
);

    logic [STAT_W-1:0] c0_grants;
    logic [STAT_W-1:0] c1_grants;
    logic [STAT_W-1:0] contention_cnt;
    logic [STAT_W-1:0] stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c0_grants      <= '0;
            c1_grants      <= '0;
            contention_cnt <= '0;
            stall_cycles   <= '0;
        end else begin
            if (c0_grant)   c0_grants      <= c0_grants + STAT_W'(1);
            if (c1_grant)   c1_grants      <= c1_grants + STAT_W'(1);
            if (contention) contention_cnt <= contention_cnt + STAT_W'(1);
            if (stall)      stall_cycles   <= stall_cycles + STAT_W'(1);
        end
    end

    always_comb begin
        arb_statistics = '0;
        arb_statistics[STAT_C0_LSB    +: STAT_W] = c0_grants;
        arb_statistics[STAT_C1_LSB    +: STAT_W] = c1_grants;
        arb_statistics[STAT_CONT_LSB  +: STAT_W] = contention_cnt;
        arb_statistics[STAT_STALL_LSB +: STAT_W] = stall_cycles;
    end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 request port between two L1 controllers,
// with a fixed release gap between owners.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned n          = 32,
    parameter int unsigned AW         = 10,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] c0_word_address,
    input  logic [AW-1:0] c1_word_address,
    input  logic [n-1:0]  c0_wdata,
    input  logic [n-1:0]  c1_wdata,
    input  logic          c0_read_request,
    input  logic          c0_write_request,
    input  logic          c1_read_request,
    input  logic          c1_write_request,
    output logic [n-1:0]  c0_rdata,
    output logic [n-1:0]  c1_rdata,
    output logic          c0_busy,
    output logic          c1_busy,
    output logic [AW-1:0] l2_word_address,
    output logic [n-1:0]  l2_wdata,
    output logic          l2_read_request,
    output logic          l2_write_request,
    input  logic [n-1:0]  l2_rdata,
    input  logic          l2_busy,
    output logic          owner,
    output logic [31:0]   arb_statistics
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t    state_q, state_d;
    core_id_t      owner_q, owner_d;
    core_id_t      last_q, last_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] addr_q;
    logic [n-1:0]  wdata_q;

    logic          req0, req1, other_req;
    logic          own_rd, own_wr;
    logic [AW-1:0] own_addr;
    logic [n-1:0]  own_wdata;
    logic          grant0, grant1, contention, stall;
    logic          in_own;

    assign req0      = c0_read_request | c0_write_request;
    assign req1      = c1_read_request | c1_write_request;
    assign other_req = owner_q ? req0 : req1;
    assign own_rd    = owner_q ? c1_read_request  : c0_read_request;
    assign own_wr    = owner_q ? c1_write_request : c0_write_request;
    assign own_addr  = owner_q ? c1_word_address  : c0_word_address;
    assign own_wdata = owner_q ? c1_wdata         : c0_wdata;
    assign in_own    = (state_q == OWN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gap_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            if (in_own) begin
                addr_q  <= own_addr;
                wdata_q <= own_wdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        gap_d      = gap_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        contention = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                // On contention the core that did not own the port last wins.
                if (req0 && req1) begin
                    owner_d    = ~last_q;
                    grant0     = last_q;
                    grant1     = ~last_q;
                    contention = 1'b1;
                    state_d    = OWN;
                end else if (req0) begin
                    owner_d = 1'b0;
                    grant0  = 1'b1;
                    state_d = OWN;
                end else if (req1) begin
                    owner_d = 1'b1;
                    grant1  = 1'b1;
                    state_d = OWN;
                end
            end
            OWN: begin
                stall = other_req;
                if (!own_rd && !own_wr) begin
                    state_d = RELEASE;
                    gap_d   = GW'(GAP_CYCLES - 1);
                    last_d  = owner_q;
                end
            end
            RELEASE: begin
                stall = other_req;
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign l2_word_address  = in_own ? own_addr : addr_q;
    assign l2_wdata         = in_own ? own_wdata : wdata_q;
    assign l2_read_request  = in_own & own_rd;
    assign l2_write_request = in_own & own_wr;

    assign c0_busy  = (in_own && !owner_q) ? l2_busy : req0;
    assign c1_busy  = (in_own &&  owner_q) ? l2_busy : req1;
    assign c0_rdata = l2_rdata;
    assign c1_rdata = l2_rdata;
    assign owner    = owner_q;

    l2_arb_stats u_stats (
        .clk            (clk),
        .reset          (reset),
        .c0_grant       (grant0),
        .c1_grant       (grant1),
        .contention     (contention),
        .stall          (stall),
        .arb_statistics (arb_statistics)
    );

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: a vector table for the contention walk plus
// hand-written multi-cycle sequences.
module tb_l2_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  c0_word_address, c1_word_address;
    logic [31:0] c0_wdata, c1_wdata;
    logic        c0_read_request, c0_write_request;
    logic        c1_read_request, c1_write_request;
    logic [31:0] c0_rdata, c1_rdata;
    logic        c0_busy, c1_busy;
    logic [9:0]  l2_word_address;
    logic [31:0] l2_wdata;
    logic        l2_read_request, l2_write_request;
    logic [31:0] l2_rdata;
    logic        l2_busy;
    logic        owner;
    logic [31:0] arb_statistics;

    int total = 0;
    int bad   = 0;

    l2_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .c0_word_address  (c0_word_address),
        .c1_word_address  (c1_word_address),
        .c0_wdata         (c0_wdata),
        .c1_wdata         (c1_wdata),
        .c0_read_request  (c0_read_request),
        .c0_write_request (c0_write_request),
        .c1_read_request  (c1_read_request),
        .c1_write_request (c1_write_request),
        .c0_rdata         (c0_rdata),
        .c1_rdata         (c1_rdata),
        .c0_busy          (c0_busy),
        .c1_busy          (c1_busy),
        .l2_word_address  (l2_word_address),
        .l2_wdata         (l2_wdata),
        .l2_read_request  (l2_read_request),
        .l2_write_request (l2_write_request),
        .l2_rdata         (l2_rdata),
        .l2_busy          (l2_busy),
        .owner            (owner),
        .arb_statistics   (arb_statistics)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in = {c0_rd, c0_wr, c1_rd, c1_wr, l2_busy}; req = {l2_rd, l2_wr}; bo = {c0_busy, c1_busy, owner}
    typedef struct {
        logic [4:0]  in;
        logic [1:0]  req;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  bo;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        c0_read_request  = 1'b0;
        c0_write_request = 1'b0;
        c1_read_request  = 1'b0;
        c1_write_request = 1'b0;
        l2_busy          = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        c0_word_address = 10'h010;
        c1_word_address = 10'h3FF;
        c0_wdata        = 32'hA5A5_0001;
        c1_wdata        = 32'h0000_1111;
        l2_rdata        = 32'hCAFE_F00D;
        clear_reqs();

        // Reset values, with core 1 requesting while reset is held.
        @(negedge clk);
        c1_read_request = 1'b1;
        #1;
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_stats", arb_statistics, 32'h0);
        chk("rst_l2_req", 32'({l2_read_request, l2_write_request}), 32'd0);
        chk("rst_l2_addr", 32'(l2_word_address), 32'h0);
        chk("rst_l2_wdata", l2_wdata, 32'h0);
        chk("rst_c0_busy", 32'(c0_busy), 32'd0);
        chk("rst_c1_busy", 32'(c1_busy), 32'd1);

        // Contention walk from reset: core 0 write, core 1 read.
        tbl[0]  = '{5'b01100, 2'b00, 10'h000, 32'h0000_0000, 3'b110};
        tbl[1]  = '{5'b01101, 2'b01, 10'h010, 32'hA5A5_0001, 3'b110};
        tbl[2]  = '{5'b01100, 2'b01, 10'h010, 32'hA5A5_0001, 3'b010};
        tbl[3]  = '{5'b00100, 2'b00, 10'h010, 32'hA5A5_0001, 3'b010};
        tbl[4]  = '{5'b00100, 2'b00, 10'h010, 32'hA5A5_0001, 3'b010};
        tbl[5]  = '{5'b00100, 2'b00, 10'h010, 32'hA5A5_0001, 3'b010};
        tbl[6]  = '{5'b00100, 2'b00, 10'h010, 32'hA5A5_0001, 3'b010};
        tbl[7]  = '{5'b00101, 2'b10, 10'h3FF, 32'h0000_1111, 3'b011};
        tbl[8]  = '{5'b00100, 2'b10, 10'h3FF, 32'h0000_1111, 3'b001};
        tbl[9]  = '{5'b00000, 2'b00, 10'h3FF, 32'h0000_1111, 3'b001};
        tbl[10] = '{5'b00000, 2'b00, 10'h3FF, 32'h0000_1111, 3'b001};
        tbl[11] = '{5'b00000, 2'b00, 10'h3FF, 32'h0000_1111, 3'b001};
        tbl[12] = '{5'b00000, 2'b00, 10'h3FF, 32'h0000_1111, 3'b001};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            {c0_read_request, c0_write_request, c1_read_request, c1_write_request, l2_busy} = tbl[i].in;
            #1;
            chk($sformatf("tbl%0d_l2_req", i), 32'({l2_read_request, l2_write_request}), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_l2_addr", i), 32'(l2_word_address), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_l2_wdata", i), l2_wdata, tbl[i].wdata);
            chk($sformatf("tbl%0d_busy_owner", i), 32'({c0_busy, c1_busy, owner}), 32'(tbl[i].bo));
            tick();
        end
        chk("tbl_stats", arb_statistics, 32'h0101_0105);

        // Single core 0 read at 0x155; core 1 raises on the drop cycle and must wait out RELEASE.
        do_reset();
        c0_word_address = 10'h155;
        c0_read_request = 1'b1;
        #1;
        chk("s_idle_l2_rd", 32'(l2_read_request), 32'd0);
        tick();
        l2_busy = 1'b1;
        #1;
        chk("s_own_l2_rd", 32'(l2_read_request), 32'd1);
        chk("s_own_addr", 32'(l2_word_address), 32'h155);
        chk("s_own_rdata", c0_rdata, 32'hCAFE_F00D);
        chk("s_own_c0_busy", 32'(c0_busy), 32'd1);
        tick();
        l2_busy = 1'b0;
        #1;
        chk("s_done_c0_busy", 32'(c0_busy), 32'd0);
        tick();
        c0_read_request = 1'b0;
        c1_read_request = 1'b1;
        #1;
        chk("s_drop_l2_rd", 32'(l2_read_request), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk($sformatf("s_gap%0d_l2_rd", k), 32'(l2_read_request), 32'd0);
            chk($sformatf("s_gap%0d_c1_busy", k), 32'(c1_busy), 32'd1);
        end
        tick();
        #1;
        chk("s_c1_l2_rd", 32'(l2_read_request), 32'd1);
        chk("s_c1_addr", 32'(l2_word_address), 32'h3FF);
        chk("s_c1_owner", 32'(owner), 32'd1);
        chk("s_stats", arb_statistics, 32'h0101_0003);
        c0_word_address = 10'h010;

        // Three contention rounds; the served core drops one cycle then re-raises in RELEASE.
        do_reset();
        c0_read_request = 1'b1;
        c1_read_request = 1'b1;
        for (int r = 0; r < 3; r++) begin
            logic exp_owner;
            exp_owner = (r == 1) ? 1'b1 : 1'b0;
            tick();
            #1;
            chk($sformatf("rr%0d_owner", r), 32'(owner), 32'(exp_owner));
            chk($sformatf("rr%0d_l2_rd", r), 32'(l2_read_request), 32'd1);
            chk($sformatf("rr%0d_addr", r), 32'(l2_word_address), exp_owner ? 32'h3FF : 32'h010);
            tick();
            if (exp_owner) c1_read_request = 1'b0;
            else           c0_read_request = 1'b0;
            #1;
            chk($sformatf("rr%0d_drop_l2_rd", r), 32'(l2_read_request), 32'd0);
            tick();
            c0_read_request = 1'b1;
            c1_read_request = 1'b1;
            #1;
            chk($sformatf("rr%0d_rel1_l2_rd", r), 32'(l2_read_request), 32'd0);
            chk($sformatf("rr%0d_rel1_busy", r), 32'({c0_busy, c1_busy}), 32'd3);
            tick();
            #1;
            chk($sformatf("rr%0d_rel2_l2_rd", r), 32'(l2_read_request), 32'd0);
            tick();
            #1;
            chk($sformatf("rr%0d_idle_l2_rd", r), 32'(l2_read_request), 32'd0);
        end
        chk("rr_stats", arb_statistics, 32'h0201_030C);

        // Reset asserted in the middle of an OWN cycle while the L2 is busy.
        do_reset();
        c0_write_request = 1'b1;
        tick();
        l2_busy = 1'b1;
        #1;
        chk("mr_own_l2_wr", 32'(l2_write_request), 32'd1);
        chk("mr_own_stats", arb_statistics, 32'h0100_0000);
        #2;
        reset   = 1'b1;
        l2_busy = 1'b0;
        #1;
        chk("mr_async_l2_wr", 32'(l2_write_request), 32'd0);
        chk("mr_async_stats", arb_statistics, 32'h0);
        chk("mr_async_c0_busy", 32'(c0_busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_idle_l2_wr", 32'(l2_write_request), 32'd0);
        chk("mr_idle_addr", 32'(l2_word_address), 32'h0);
        chk("mr_idle_owner", 32'(owner), 32'd0);
        c0_write_request = 1'b0;

        // 256 solo core 0 grants: the grant field wraps.
        do_reset();
        for (int g = 0; g < 256; g++) begin
            c0_read_request = 1'b1;
            tick();
            if (g == 254) begin
                #1;
                chk("wrap_c0_ff", 32'(arb_statistics[31:24]), 32'hFF);
            end
            c0_read_request = 1'b0;
            tick();
            tick();
            tick();
        end
        #1;
        chk("wrap_stats", arb_statistics, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
